// File: rtl/fpu_cmd_sequencer.sv
// fpu_cmd_sequencer: CPU-bus register file and launch/complete sequencer
// for the FPU arithmetic core, with a saturating completion timeout.
module fpu_cmd_sequencer #(
    parameter int unsigned TIMEOUT_CYCLES = 1023
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        cpu_wr,
    input  logic [3:0]  cpu_addr,
    input  logic [7:0]  cpu_wdata,
    output logic [7:0]  cpu_rdata,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        core_start,
    output logic [3:0]  core_op,
    output logic [31:0] core_a,
    output logic [31:0] core_b,
    input  logic [31:0] core_result,
    input  logic        core_done
);

    localparam int unsigned TW_RAW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned TW     = (TW_RAW < 1) ? 1 : TW_RAW;
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        main_idle_st,
        main_wait_st,
        main_finish_st,
        main_wait_start_low_st
    } e_main_st;

    typedef enum logic [3:0] {
        FPU_OP_ADD   = 4'h0, FPU_OP_SUB   = 4'h1, FPU_OP_MUL   = 4'h2,
        FPU_OP_DIV   = 4'h3, FPU_OP_SQRT  = 4'h4, FPU_OP_CMP   = 4'h5,
        FPU_OP_MIN   = 4'h6, FPU_OP_MAX   = 4'h7, FPU_OP_ABS   = 4'h8,
        FPU_OP_NEG   = 4'h9, FPU_OP_I2F   = 4'hA, FPU_OP_F2I   = 4'hB,
        FPU_OP_RND   = 4'hC, FPU_OP_CPY   = 4'hD, FPU_OP_SGN   = 4'hE,
        FPU_OP_INVAL = 4'hF
    } e_fpu_op;

    e_main_st      r_state;
    e_main_st      w_next;
    e_fpu_op       r_op;
    logic [31:0]   r_a;
    logic [31:0]   r_b;
    logic [31:0]   r_result;
    logic [TW-1:0] r_timer;
    logic          r_done;
    logic          r_err;
    logic          r_core_start;
    logic          w_wr_en;
    logic          w_op_invalid;
    logic          w_timeout;

    assign w_wr_en      = cpu_wr && (r_state == main_idle_st) && (cpu_addr <= 4'h8);
    assign w_op_invalid = (r_op == FPU_OP_INVAL);
    assign w_timeout    = (TIMEOUT_CYCLES != 0) && (r_timer == TMO_LAST);

    assign busy       = (r_state != main_idle_st);
    assign done       = r_done;
    assign err        = r_err;
    assign core_start = r_core_start;
    assign core_op    = r_op;
    assign core_a     = r_a;
    assign core_b     = r_b;

    // State register
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) r_state <= main_idle_st;
        else       r_state <= w_next;
    end

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            main_idle_st:           if (start) w_next = w_op_invalid ? main_finish_st : main_wait_st;
            main_wait_st:           if (core_done || w_timeout) w_next = main_finish_st;
            main_finish_st:         w_next = main_wait_start_low_st;
            main_wait_start_low_st: if (!start) w_next = main_idle_st;
            default:                w_next = main_idle_st;
        endcase
    end

    // Register file, launch pulse, timer and sticky status flags
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            r_a          <= '0;
            r_b          <= '0;
            r_op         <= FPU_OP_ADD;
            r_result     <= '0;
            r_timer      <= '0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_core_start <= 1'b0;
        end else begin
            r_core_start <= 1'b0;
            if (w_wr_en) begin
                case (cpu_addr)
                    4'h0, 4'h1, 4'h2, 4'h3: r_a[{cpu_addr[1:0], 3'b000} +: 8] <= cpu_wdata;
                    4'h4, 4'h5, 4'h6, 4'h7: r_b[{cpu_addr[1:0], 3'b000} +: 8] <= cpu_wdata;
                    default:                r_op <= e_fpu_op'(cpu_wdata[3:0]);
                endcase
            end
            case (r_state)
                main_idle_st: begin
                    if (start) begin
                        r_done <= 1'b0;
                        if (w_op_invalid) begin
                            r_err <= 1'b1;
                        end else begin
                            r_err        <= 1'b0;
                            r_core_start <= 1'b1;
                            r_timer      <= '0;
                        end
                    end
                end
                main_wait_st: begin
                    // core_done takes priority over a coincident timeout
                    if (core_done) begin
                        r_result <= core_result;
                        r_done   <= 1'b1;
                    end else if (w_timeout) begin
                        r_result <= '1;
                        r_err    <= 1'b1;
                        r_done   <= 1'b1;
                    end else if (r_timer != '1) begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                main_finish_st: begin
                    if (w_op_invalid) r_done <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Combinational CPU read mux
    always_comb begin
        cpu_rdata = '0;
        case (cpu_addr)
            4'h0, 4'h1, 4'h2, 4'h3: cpu_rdata = r_a[{cpu_addr[1:0], 3'b000} +: 8];
            4'h4, 4'h5, 4'h6, 4'h7: cpu_rdata = r_b[{cpu_addr[1:0], 3'b000} +: 8];
            4'h8:                   cpu_rdata = {4'b0000, r_op};
            4'h9:                   cpu_rdata = {5'b00000, r_err, r_done, busy};
            4'hC, 4'hD, 4'hE, 4'hF: cpu_rdata = r_result[{cpu_addr[1:0], 3'b000} +: 8];
            default:                cpu_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_fpu_cmd_sequencer.sv
// tb_fpu_cmd_sequencer: scoreboard bench for fpu_cmd_sequencer with a
// hand-driven core model and an 8-cycle timeout.
`timescale 1ns/1ps
module tb_fpu_cmd_sequencer;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        cpu_wr;
    logic [3:0]  cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [7:0]  cpu_rdata;
    logic        start;
    logic        busy;
    logic        done;
    logic        err;
    logic        core_start;
    logic [3:0]  core_op;
    logic [31:0] core_a;
    logic [31:0] core_b;
    logic [31:0] core_result;
    logic        core_done;

    int n_checks = 0;
    int n_errors = 0;
    int n_launch = 0;
    int l0;
    logic [7:0]  b;
    logic [31:0] w;
    logic [32:0] sb_q[$];

    fpu_cmd_sequencer #(.TIMEOUT_CYCLES(8)) dut (
        .clk(clk), .arst(arst), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .start(start),
        .busy(busy), .done(done), .err(err), .core_start(core_start),
        .core_op(core_op), .core_a(core_a), .core_b(core_b),
        .core_result(core_result), .core_done(core_done)
    );

    always #10 clk = ~clk;

    always @(negedge clk) if (core_start) n_launch++;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] a, input logic [7:0] d);
        cpu_wr = 1'b1; cpu_addr = a; cpu_wdata = d;
        @(negedge clk);
        cpu_wr = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [7:0] d);
        cpu_addr = a;
        #1;
        d = cpu_rdata;
    endtask

    task automatic wr32(input logic [3:0] base, input logic [31:0] v);
        for (int i = 0; i < 4; i++) wr(base + 4'(i), v[8*i +: 8]);
    endtask

    task automatic rd32(input logic [3:0] base, output logic [31:0] v);
        logic [7:0] t;
        for (int i = 0; i < 4; i++) begin
            rd(base + 4'(i), t);
            v[8*i +: 8] = t;
        end
    endtask

    task automatic sb_check(input string tag);
        logic [32:0] e;
        logic [31:0] r;
        if (sb_q.size() == 0) begin
            check({tag, "_sb_empty"}, 64'd1, 64'd0);
        end else begin
            e = sb_q.pop_front();
            rd32(4'hC, r);
            check({tag, "_result"}, r, e[31:0]);
            check({tag, "_err"}, err, e[32]);
        end
    endtask

    initial begin
        cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0; start = 0;
        core_result = 0; core_done = 0;

        // reset
        #1 arst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_cs", core_start, 0);
        rd(4'h9, b);
        check("rst_status", b, 8'h00);
        check("rst_core_a", core_a, 0);
        arst = 1'b1;
        @(negedge clk);

        // add: core responds 5 cycles after launch
        wr32(4'h0, 32'h3FC00000);
        wr32(4'h4, 32'h40000000);
        wr(4'h8, 8'h00);
        l0 = n_launch;
        sb_q.push_back({1'b0, 32'h40600000});
        start = 1'b1;
        @(negedge clk);
        check("add_cs", core_start, 1);
        check("add_busy", busy, 1);
        check("add_core_a", core_a, 32'h3FC00000);
        check("add_core_b", core_b, 32'h40000000);
        check("add_core_op", core_op, 4'h0);
        @(negedge clk);
        check("add_cs_drop", core_start, 0);
        repeat (3) @(negedge clk);
        check("add_pre_done", done, 0);
        core_done = 1'b1; core_result = 32'h40600000;
        @(negedge clk);
        core_done = 1'b0; core_result = 0;
        check("add_done", done, 1);
        sb_check("add");
        check("add_busy_fin", busy, 1);
        @(negedge clk);
        check("add_busy_wsl", busy, 1);
        start = 1'b0;
        @(negedge clk);
        check("add_idle", busy, 0);
        check("add_sticky", done, 1);
        check("add_one_pulse", n_launch - l0, 1);

        // invalid opcode
        wr(4'h8, 8'h0F);
        l0 = n_launch;
        sb_q.push_back({1'b1, 32'h40600000});
        start = 1'b1;
        @(negedge clk);
        rd(4'h9, b);
        check("inv_fin_status", b, 8'h05);
        @(negedge clk);
        rd(4'h9, b);
        check("inv_wsl_status", b, 8'h07);
        sb_check("inv");
        @(negedge clk);
        rd(4'h9, b);
        check("inv_hold_status", b, 8'h07);
        start = 1'b0;
        @(negedge clk);
        rd(4'h9, b);
        check("inv_idle_status", b, 8'h06);
        check("inv_no_launch", n_launch - l0, 0);

        // timeout, then late core_done
        wr(4'h8, 8'h02);
        sb_q.push_back({1'b1, 32'hFFFFFFFF});
        start = 1'b1;
        @(negedge clk);
        repeat (7) @(negedge clk);
        check("to_pre_err", err, 0);
        check("to_pre_done", done, 0);
        @(negedge clk);
        check("to_err", err, 1);
        check("to_done", done, 1);
        sb_check("to");
        core_done = 1'b1; core_result = 32'h12345678;
        @(negedge clk);
        core_done = 1'b0; core_result = 0;
        rd32(4'hC, w);
        check("to_late_ignored", w, 32'hFFFFFFFF);
        check("to_err_hold", err, 1);
        start = 1'b0;
        @(negedge clk);
        check("to_idle", busy, 0);

        // core_done on the timeout cycle wins
        sb_q.push_back({1'b0, 32'hCAFEF00D});
        start = 1'b1;
        @(negedge clk);
        repeat (7) @(negedge clk);
        core_done = 1'b1; core_result = 32'hCAFEF00D;
        @(negedge clk);
        core_done = 1'b0; core_result = 0;
        check("co_done", done, 1);
        sb_check("co");
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("co_idle", busy, 0);

        // writes while busy are dropped
        wr(4'h8, 8'h00);
        sb_q.push_back({1'b0, 32'h11223344});
        start = 1'b1;
        @(negedge clk);
        wr(4'h0, 8'hAA);
        check("bw_busy_a", core_a, 32'h3FC00000);
        core_done = 1'b1; core_result = 32'h11223344;
        @(negedge clk);
        core_done = 1'b0; core_result = 0;
        sb_check("bw");
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("bw_idle", busy, 0);
        wr(4'h0, 8'hAA);
        check("bw_idle_a", core_a, 32'h3FC000AA);

        // asynchronous reset three cycles into WAIT
        start = 1'b1;
        repeat (3) @(negedge clk);
        #3 arst = 1'b0;
        #1;
        check("rm_busy", busy, 0);
        check("rm_done", done, 0);
        check("rm_err", err, 0);
        check("rm_cs", core_start, 0);
        check("rm_core_a", core_a, 0);
        rd(4'h9, b);
        check("rm_status", b, 8'h00);
        start = 1'b0;
        @(negedge clk);
        arst = 1'b1;
        core_done = 1'b1; core_result = 32'hDEADBEEF;
        @(negedge clk);
        core_done = 1'b0; core_result = 0;
        check("rm_post_busy", busy, 0);
        check("rm_post_done", done, 0);
        rd32(4'hC, w);
        check("rm_post_result", w, 32'h0);

        // normal op after reset, 1-cycle core
        wr32(4'h0, 32'h40400000);
        wr32(4'h4, 32'h3F800000);
        wr(4'h8, 8'h01);
        sb_q.push_back({1'b0, 32'h40000000});
        start = 1'b1;
        @(negedge clk);
        check("rm2_cs", core_start, 1);
        core_done = 1'b1; core_result = 32'h40000000;
        @(negedge clk);
        core_done = 1'b0; core_result = 0;
        check("rm2_done", done, 1);
        sb_check("rm2");
        start = 1'b0;
        repeat (2) @(negedge clk);
        check("rm2_idle", busy, 0);
        check("sb_drained", sb_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
